multi_digit_serial_adder: RTL and testbench
===========================================

# multi_digit_serial_adder

Parametrised sequential adder/subtractor built from a DIGIT-bit full-adder slice. The slice is reused over WIDTH/DIGIT clock cycles with a registered carry between digits. It sits in the adders library as the multi-cycle, area-lean successor to the single-bit combinational full adder. A start/busy/done handshake lets a controller issue one operation at a time, and the block reports carry-out and signed overflow.

## Interface
- WIDTH, 16: operand and result width in bits.
- DIGIT, 4: bits processed per cycle. Must divide WIDTH; DIGIT = WIDTH is legal and gives a single-step operation.
- Derived: STEPS = WIDTH/DIGIT. Counter width = clog2(STEPS), minimum 1 bit.

- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy = 0.
- A  in  WIDTH  operand A; sampled with start.
- B  in  WIDTH  operand B; sampled with start.
- Cin  in  1  carry-in; used only when SUB = 0.
- SUB  in  1  0: compute A+B+Cin. 1: compute A−B as A+~B+1, with Cin ignored.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; SUM, Cout and OVF are valid from this cycle.
- SUM  out  WIDTH  registered result.
- Cout  out  1  carry out of bit WIDTH−1. When SUB = 1, Cout = 1 means no borrow.
- OVF  out  1  two's-complement signed overflow.

## Operation
- States: IDLE and RUN.
- **IDLE, start = 1:**
  - Latch A into opa.
  - Latch B into opb, inverting it when SUB = 1.
  - Load the carry register with (SUB ? 1 : Cin).
  - Clear the step counter.
  - Go to RUN.
- **IDLE, start = 0:** stay in IDLE.
- **RUN, each cycle:**
  - Add digit[step] of opa and opb plus the carry register.
  - Write the DIGIT-bit sum into the accumulator at digit position step.
  - Write the digit carry-out into the carry register.
  - Increment step.
- **RUN, final step (step = STEPS−1):**
  - Transfer the completed accumulator to SUM.
  - Set Cout to the final carry.
  - Set OVF = (opa[WIDTH−1] == opb[WIDTH−1]) && (SUM[WIDTH−1] != opa[WIDTH−1]).
  - Pulse done.
  - Go to IDLE.
- SUM, Cout and OVF hold their values until the next done. They do not change during RUN.
- start is ignored while busy = 1. Operands do not need to be held after the start cycle.
- All arithmetic is modulo 2^WIDTH. Bits above WIDTH−1 are never produced.

## Timing
- Reset, asynchronous on rst_n low:
  - State goes to IDLE; busy, done, SUM, Cout, OVF, accumulator and counter go to 0.
  - Any operation in progress is aborted with no done pulse.
  - Release is synchronous to clk, and the first start is accepted on the first edge after rst_n goes high.
- start is sampled at edge k:
  - busy = 1 from edge k.
  - Digits 0..STEPS−1 are processed on edges k+1 .. k+STEPS.
  - At edge k+STEPS, busy goes to 0, done goes to 1 and results update.
  - done drops at edge k+STEPS+1 unless another operation completes on that edge.
- Latency from start sample to done is STEPS cycles. With DIGIT = WIDTH, done follows start by one cycle.
- Back-to-back operation: start may be high during the done cycle, because busy = 0 then.
  - That start is accepted at edge k+STEPS+1.
  - Sustained throughput is one result per STEPS+1 cycles.
- busy and done are never high in the same cycle.

## Test plan
WIDTH = 16 and DIGIT = 4 (STEPS = 4) unless stated otherwise.
- **Reset:** hold rst_n = 0 for 3 cycles with random inputs -> busy = done = SUM = Cout = OVF = 0. Release rst_n, then pulse start -> done exactly 4 cycles later.
- **Add with carry and overflow:**
  - A = 16'h00FF, B = 16'h0001, Cin = 0, SUB = 0 -> SUM = 16'h0100, Cout = 0, OVF = 0.
  - A = 16'hFFFF, B = 16'h0001, Cin = 1 -> SUM = 16'h0001, Cout = 1, OVF = 0.
  - A = 16'h7FFF, B = 16'h0001, Cin = 0 -> SUM = 16'h8000, Cout = 0, OVF = 1.
- **Subtract:**
  - A = 16'h0005, B = 16'h0007, SUB = 1, Cin = 1 (Cin must be ignored) -> SUM = 16'hFFFE, Cout = 0, OVF = 0.
  - A = 16'h8000, B = 16'h0001, SUB = 1 -> SUM = 16'h7FFF, Cout = 1, OVF = 1.
- **Handshake:**
  - Pulse start, then change A/B and reassert start during cycles 2–3 of RUN -> the first result is unaffected and no second operation starts.
  - Assert start during the done cycle -> a second done arrives 5 cycles after the first, with the correct second result.
- **Abort:** drop rst_n during step 2 of RUN -> no done pulse and all outputs 0. A new operation after release completes correctly.
- **Exhaustive parameter sweep:**
  - WIDTH = 3, DIGIT = 1: all A, B, Cin, SUB combinations compared against a reference model for SUM, Cout and OVF, with done after 3 cycles.
  - WIDTH = 8, DIGIT = 8: the same model comparison for random operands, with done after 1 cycle.

Source files
------------

// File: rtl/multi_digit_serial_adder.sv
// multi_digit_serial_adder
//
// Sequential adder/subtractor that reuses one DIGIT-bit adder slice over
// WIDTH/DIGIT clock cycles, with a registered carry between digits.
// Subtraction is computed as A + ~B + 1.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only while busy = 0
//   A, B   in   WIDTH-bit operands, sampled with start
//   Cin    in   carry-in, used only for addition
//   SUB    in   0: A+B+Cin, 1: A-B
//   busy   out  operation in progress
//   done   out  one-cycle pulse; SUM/Cout/OVF valid from this cycle
//   SUM    out  WIDTH-bit registered result
//   Cout   out  carry out of the top bit (1 = no borrow when subtracting)
//   OVF    out  two's-complement signed overflow
module multi_digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             SUB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SUM,
    output logic             Cout,
    output logic             OVF
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    step;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT:0]   dig_res;
    logic [WIDTH-1:0] acc_next;

    // One DIGIT-bit slice: returns {carry_out, sum}.
    function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                                 input logic [DIGIT-1:0] y,
                                                 input logic             ci);
        digit_add = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
    endfunction

    // Accumulator with the current digit merged in; on the final step this
    // is the complete result, so SUM and OVF are taken from it directly.
    always_comb begin
        dig_a    = opa[int'(step)*DIGIT +: DIGIT];
        dig_b    = opb[int'(step)*DIGIT +: DIGIT];
        dig_res  = digit_add(dig_a, dig_b, carry);
        acc_next = acc;
        acc_next[int'(step)*DIGIT +: DIGIT] = dig_res[DIGIT-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            step  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            SUM   <= '0;
            Cout  <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= A;
                        // opb holds the operand actually added, so the
                        // overflow test below works for both add and sub.
                        opb   <= SUB ? ~B : B;
                        carry <= SUB | Cin;
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= dig_res[DIGIT];
                    step  <= step + 1'b1;
                    if (step == LAST) begin
                        SUM   <= acc_next;
                        Cout  <= dig_res[DIGIT];
                        OVF   <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                                 (acc_next[WIDTH-1] != opa[WIDTH-1]);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        step  <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_digit_serial_adder.sv
// Directed bench for multi_digit_serial_adder: a 16/4 instance for the main
// tests plus 3/1 and 8/8 instances for the parameter sweeps.
module tb_multi_digit_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 16/4 instance
    logic        start16 = 0, cin16 = 0, sub16 = 0;
    logic [15:0] a16 = 0, b16 = 0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;
    // 3/1 instance
    logic        start3 = 0, cin3 = 0, sub3 = 0;
    logic [2:0]  a3 = 0, b3 = 0;
    logic        busy3, done3, cout3, ovf3;
    logic [2:0]  sum3;
    // 8/8 instance
    logic        start8 = 0, cin8 = 0, sub8 = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;

    multi_digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .A(a16), .B(b16),
        .Cin(cin16), .SUB(sub16), .busy(busy16), .done(done16),
        .SUM(sum16), .Cout(cout16), .OVF(ovf16));

    multi_digit_serial_adder #(.WIDTH(3), .DIGIT(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .A(a3), .B(b3),
        .Cin(cin3), .SUB(sub3), .busy(busy3), .done(done3),
        .SUM(sum3), .Cout(cout3), .OVF(ovf3));

    multi_digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .Cin(cin8), .SUB(sub8), .busy(busy8), .done(done8),
        .SUM(sum8), .Cout(cout8), .OVF(ovf8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel_done(input int which);
        case (which)
            0:       sel_done = done16;
            1:       sel_done = done3;
            default: sel_done = done8;
        endcase
    endfunction

    function automatic logic sel_busy(input int which);
        case (which)
            0:       sel_busy = busy16;
            1:       sel_busy = busy3;
            default: sel_busy = busy8;
        endcase
    endfunction

    // Reference: w-bit A + (SUB ? ~B : B) + (SUB ? 1 : Cin).
    task automatic ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          output logic [15:0] s, output logic c, output logic o);
        logic [16:0] mask;
        logic [16:0] bb;
        logic [16:0] full;
        mask = (17'd1 << w) - 17'd1;
        bb   = sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
        full = ({1'b0, a} & mask) + bb + (sub ? 17'd1 : {16'd0, cin});
        s    = full[15:0] & mask[15:0];
        c    = full[w];
        o    = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    endtask

    // Issues one operation from posedge+1 and waits (bounded) for done.
    task automatic run_op(input int which, input string tag,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          output logic [15:0] s, output logic c, output logic o,
                          output int lat);
        case (which)
            0: begin a16 = a; b16 = b; cin16 = cin; sub16 = sub; start16 = 1; end
            1: begin a3 = a[2:0]; b3 = b[2:0]; cin3 = cin; sub3 = sub; start3 = 1; end
            default: begin a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; sub8 = sub; start8 = 1; end
        endcase
        @(posedge clk); #1;
        start16 = 0; start3 = 0; start8 = 0;
        // operands need not be held after the start cycle
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = ~cin16; sub16 = ~sub16;
        a3 = 3'($urandom); b3 = 3'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom);
        if (which == 0) chk({tag, "_busy_after_start"}, 32'(busy16), 32'd1);
        lat = 0;
        while (!sel_done(which) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_busy_at_done"}, 32'(sel_busy(which)), 32'd0);
        case (which)
            0:       begin s = sum16; c = cout16; o = ovf16; end
            1:       begin s = {13'd0, sum3}; c = cout3; o = ovf3; end
            default: begin s = {8'd0, sum8}; c = cout8; o = ovf8; end
        endcase
    endtask

    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        input logic [15:0] es, input logic ec, input logic eo);
        logic [15:0] s;
        logic        c, o;
        int          lat;
        run_op(0, tag, a, b, cin, sub, s, c, o, lat);
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        chk({tag, "_sum"}, 32'(s), 32'(es));
        chk({tag, "_cout"}, 32'(c), 32'(ec));
        chk({tag, "_ovf"}, 32'(o), 32'(eo));
    endtask

    initial begin
        logic [15:0] s, es;
        logic        c, o, ec, eo;
        int          lat, t1, seen;

        // Reset held for 3 cycles with random inputs
        rst_n = 0;
        for (int i = 0; i < 3; i++) begin
            start16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
            cin16 = 1'($urandom); sub16 = 1'($urandom);
            @(posedge clk); #1;
        end
        chk("rst_busy", 32'(busy16), 0);
        chk("rst_done", 32'(done16), 0);
        chk("rst_sum", 32'(sum16), 0);
        chk("rst_cout", 32'(cout16), 0);
        chk("rst_ovf", 32'(ovf16), 0);
        start16 = 0;
        rst_n = 1;
        // first start accepted on the first edge after release
        op16("post_rst", 16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0);

        // Add
        op16("add_ff_1", 16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0);
        op16("add_wrap", 16'hFFFF, 16'h0001, 1, 0, 16'h0001, 1, 0);
        op16("add_ovf", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
        // Subtract (Cin ignored)
        op16("sub_neg", 16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0);
        op16("sub_ovf", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);

        // start and operand changes during RUN are ignored
        a16 = 16'h1111; b16 = 16'h2222; cin16 = 0; sub16 = 0; start16 = 1;
        @(posedge clk); #1;
        start16 = 0;
        @(posedge clk); #1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1; start16 = 1;
        @(posedge clk); #1;
        chk("hs_busy_mid", 32'(busy16), 1);
        @(posedge clk); #1;
        start16 = 0;
        @(posedge clk); #1;
        chk("hs_done", 32'(done16), 1);
        chk("hs_sum", 32'(sum16), 32'h3333);
        chk("hs_cout", 32'(cout16), 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (busy16 || done16) seen++;
        end
        chk("hs_no_second_op", 32'(seen), 0);
        chk("hs_sum_held", 32'(sum16), 32'h3333);

        // Back-to-back: start during the done cycle
        op16("b2b_first", 16'h0010, 16'h0020, 0, 0, 16'h0030, 0, 0);
        t1 = cyc;
        op16("b2b_second", 16'h0100, 16'h0001, 0, 1, 16'h00FF, 1, 0);
        chk("b2b_spacing", 32'(cyc - t1), 32'd5);

        // Abort: reset during step 2 of RUN
        a16 = 16'h0F0F; b16 = 16'h0101; cin16 = 0; sub16 = 0; start16 = 1;
        @(posedge clk); #1;
        start16 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("abort_busy", 32'(busy16), 0);
        chk("abort_sum", 32'(sum16), 0);
        chk("abort_cout", 32'(cout16), 0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done16 || busy16 || ovf16) seen++;
        end
        chk("abort_quiet", 32'(seen), 0);
        rst_n = 1;
        op16("after_abort", 16'h4000, 16'h4000, 1, 0, 16'h8001, 0, 1);

        // WIDTH=3, DIGIT=1 exhaustive
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int k = 0; k < 4; k++) begin
                    ref_op(3, 16'(a), 16'(b), k[0], k[1], es, ec, eo);
                    run_op(1, "w3", 16'(a), 16'(b), k[0], k[1], s, c, o, lat);
                    chk("w3_lat", 32'(lat), 32'd3);
                    chk($sformatf("w3_sum_%0d_%0d_%0d", a, b, k), 32'(s), 32'(es));
                    chk($sformatf("w3_cout_%0d_%0d_%0d", a, b, k), 32'(c), 32'(ec));
                    chk($sformatf("w3_ovf_%0d_%0d_%0d", a, b, k), 32'(o), 32'(eo));
                end

        // WIDTH=8, DIGIT=8 random
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            logic        rc, rs;
            ra = 16'($urandom_range(255)); rb = 16'($urandom_range(255));
            rc = 1'($urandom); rs = 1'($urandom);
            ref_op(8, ra, rb, rc, rs, es, ec, eo);
            run_op(2, "w8", ra, rb, rc, rs, s, c, o, lat);
            chk("w8_lat", 32'(lat), 32'd1);
            chk($sformatf("w8_sum_%0h_%0h_%0d%0d", ra, rb, rc, rs), 32'(s), 32'(es));
            chk($sformatf("w8_cout_%0h_%0h_%0d%0d", ra, rb, rc, rs), 32'(c), 32'(ec));
            chk($sformatf("w8_ovf_%0h_%0h_%0d%0d", ra, rb, rc, rs), 32'(o), 32'(eo));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // busy and done must never be high together on the main instance
    always @(negedge clk) begin
        if (rst_n && busy16 && done16) begin
            nvec++;
            nerr++;
            $error("FAIL busy_done_overlap: observed busy=%0b done=%0b expected not both", busy16, done16);
        end
    end

endmodule
